// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter that sends NUM_WORDS words back to back.
// Each word is a start bit, DATA_BITS data bits LSB-first, an optional parity
// bit and STOP_BITS stop bits. An optional idle gap separates words.
// Ports:
//   clk_9k6hz : clock (the bit clock when CLKS_PER_BIT=1)
//   rst       : asynchronous active-high reset
//   en        : start request, sampled only while idle
//   data      : frame payload, word k = data[k*DATA_BITS +: DATA_BITS]
//   tx        : registered serial line, idle high
//   busy      : high while a frame is in progress
//   done      : one-cycle pulse on the first idle cycle after a frame
module uart_tx_frame #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_WORDS    = 2,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned GAP_BITS     = 0
) (
  input  logic                           clk_9k6hz,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_WORDS*DATA_BITS-1:0] data,
  output logic                           tx,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned FRAME_W = NUM_WORDS * DATA_BITS;
  localparam int unsigned CLK_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_MAX_A = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int unsigned BIT_MAX = (BIT_MAX_A > GAP_BITS) ? BIT_MAX_A : GAP_BITS;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam int unsigned WORD_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic        PAR_EN  = (PARITY != 0);
  localparam logic        PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t               r_state, w_next_state;
  logic [CLK_W-1:0]     r_clk_cnt, w_clk_cnt;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt;
  logic [WORD_W-1:0]    r_word, w_word;
  logic [FRAME_W-1:0]   r_shift, w_shift;
  logic                 r_par, w_par;
  logic                 w_tick;
  logic                 w_tx;
  logic                 w_done;

  // Bit-period boundary from the prescaler
  assign w_tick = (r_clk_cnt == CLK_W'(CLKS_PER_BIT - 1));

  // State register and registered outputs
  always_ff @(posedge clk_9k6hz or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_word    <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_clk_cnt <= w_clk_cnt;
      r_bit_cnt <= w_bit_cnt;
      r_word    <= w_word;
      r_shift   <= w_shift;
      r_par     <= w_par;
      tx        <= w_tx;
      busy      <= (w_next_state != S_IDLE);
      done      <= w_done;
    end
  end

  // Next-state, counters and next line value
  always_comb begin
    w_next_state = r_state;
    w_clk_cnt    = r_clk_cnt;
    w_bit_cnt    = r_bit_cnt;
    w_word       = r_word;
    w_shift      = r_shift;
    w_par        = r_par;
    w_done       = 1'b0;
    w_tx         = 1'b1;

    // Prescaler reloads on every bit boundary, held at zero while idle
    if (r_state == S_IDLE) begin
      w_clk_cnt = '0;
    end else if (w_tick) begin
      w_clk_cnt = '0;
    end else begin
      w_clk_cnt = CLK_W'(r_clk_cnt + 1'b1);
    end

    unique case (r_state)
      S_IDLE: begin
        if (en) begin
          w_next_state = S_START;
          w_shift      = data;
          w_word       = '0;
          w_bit_cnt    = '0;
          w_par        = 1'b0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_next_state = S_DATA;
          w_bit_cnt    = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          // Words sit contiguously, so shifting runs straight into the next word
          w_shift = {1'b0, r_shift[FRAME_W-1:1]};
          w_par   = r_par ^ r_shift[0];
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            w_bit_cnt    = '0;
            w_next_state = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt = BIT_W'(r_bit_cnt + 1'b1);
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_next_state = S_STOP;
          w_bit_cnt    = '0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            w_bit_cnt = '0;
            if (r_word == WORD_W'(NUM_WORDS - 1)) begin
              w_next_state = S_IDLE;
              w_done       = 1'b1;
            end else begin
              w_word       = WORD_W'(r_word + 1'b1);
              w_par        = 1'b0;
              w_next_state = (GAP_BITS > 0) ? S_GAP : S_START;
            end
          end else begin
            w_bit_cnt = BIT_W'(r_bit_cnt + 1'b1);
          end
        end
      end
      S_GAP: begin
        if (w_tick) begin
          if (r_bit_cnt == BIT_W'(GAP_BITS - 1)) begin
            w_bit_cnt    = '0;
            w_next_state = S_START;
          end else begin
            w_bit_cnt = BIT_W'(r_bit_cnt + 1'b1);
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Line value for the state being entered, so tx comes straight from a flop
    unique case (w_next_state)
      S_START:  w_tx = 1'b0;
      S_DATA:   w_tx = w_shift[0];
      S_PARITY: w_tx = w_par ^ PAR_ODD;
      default:  w_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed, table-driven bench for uart_tx_frame using four
// instances with different parameter sets.
module tb_uart_tx_frame;

  logic        clk;
  logic        rst;
  logic        en_a, en_b, en_c, en_d;
  logic [15:0] data_a, data_d;
  logic [7:0]  data_b, data_c;
  logic        tx_a, tx_b, tx_c, tx_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        done_a, done_b, done_c, done_d;

  int checks = 0;
  int errors = 0;

  // A: defaults
  uart_tx_frame u_a (
    .clk_9k6hz(clk), .rst(rst), .en(en_a), .data(data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );
  // B: even parity, one word
  uart_tx_frame #(.NUM_WORDS(1), .PARITY(1)) u_b (
    .clk_9k6hz(clk), .rst(rst), .en(en_b), .data(data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );
  // C: odd parity, one word
  uart_tx_frame #(.NUM_WORDS(1), .PARITY(2)) u_c (
    .clk_9k6hz(clk), .rst(rst), .en(en_c), .data(data_c),
    .tx(tx_c), .busy(busy_c), .done(done_c)
  );
  // D: prescaled, two stop bits, one-bit gap
  uart_tx_frame #(.CLKS_PER_BIT(4), .STOP_BITS(2), .GAP_BITS(1)) u_d (
    .clk_9k6hz(clk), .rst(rst), .en(en_d), .data(data_d),
    .tx(tx_d), .busy(busy_d), .done(done_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] data;
    logic [19:0] exp;   // expected tx, exp[19] first
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic get_tx(input int id);
    case (id)
      0: return tx_a;
      1: return tx_b;
      2: return tx_c;
      default: return tx_d;
    endcase
  endfunction

  function automatic logic get_busy(input int id);
    case (id)
      0: return busy_a;
      1: return busy_b;
      2: return busy_c;
      default: return busy_d;
    endcase
  endfunction

  function automatic logic get_done(input int id);
    case (id)
      0: return done_a;
      1: return done_b;
      2: return done_c;
      default: return done_d;
    endcase
  endfunction

  task automatic set_en(input int id, input logic v);
    case (id)
      0: en_a = v;
      1: en_b = v;
      2: en_c = v;
      default: en_d = v;
    endcase
  endtask

  task automatic set_data(input int id, input logic [15:0] d);
    case (id)
      0: data_a = d;
      1: data_b = d[7:0];
      2: data_c = d[7:0];
      default: data_d = d;
    endcase
  endtask

  // Pulse en for one cycle, then check every bit period and the done pulse
  task automatic run_frame(input int id, input logic [15:0] d, input logic [127:0] exp,
                           input int nbits, input int cpb, input string nm);
    set_data(id, d);
    set_en(id, 1'b1);
    @(negedge clk);
    set_en(id, 1'b0);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        chk($sformatf("%s tx bit%0d cyc%0d", nm, b, c), get_tx(id), exp[nbits-1-b]);
        chk($sformatf("%s busy bit%0d cyc%0d", nm, b, c), get_busy(id), 1'b1);
        @(negedge clk);
      end
    end
    chk($sformatf("%s done pulse", nm), get_done(id), 1'b1);
    chk($sformatf("%s busy at done", nm), get_busy(id), 1'b0);
    chk($sformatf("%s tx at done", nm), get_tx(id), 1'b1);
    @(negedge clk);
    chk($sformatf("%s done cleared", nm), get_done(id), 1'b0);
    chk($sformatf("%s tx idle", nm), get_tx(id), 1'b1);
  endtask

  logic [19:0] seq_a55a;
  logic [19:0] seq_1234;
  int          done_cnt;

  initial begin
    vecs[0] = '{data: 16'hA55A, exp: 20'b0_01011010_1_0_10100101_1};
    vecs[1] = '{data: 16'h0000, exp: 20'b0_00000000_1_0_00000000_1};
    vecs[2] = '{data: 16'hFFFF, exp: 20'b0_11111111_1_0_11111111_1};
    vecs[3] = '{data: 16'h1234, exp: 20'b0_00101100_1_0_01001000_1};
    vecs[4] = '{data: 16'h8001, exp: 20'b0_10000000_1_0_00000001_1};
    seq_a55a = vecs[0].exp;
    seq_1234 = vecs[3].exp;

    rst = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    data_a = '0; data_b = '0; data_c = '0; data_d = '0;
    repeat (2) @(negedge clk);
    for (int id = 0; id < 4; id++) begin
      chk($sformatf("reset tx dut%0d", id), get_tx(id), 1'b1);
      chk($sformatf("reset busy dut%0d", id), get_busy(id), 1'b0);
      chk($sformatf("reset done dut%0d", id), get_done(id), 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Default configuration, table of payloads
    for (int i = 0; i < 5; i++)
      run_frame(0, vecs[i].data, {108'b0, vecs[i].exp}, 20, 1, $sformatf("A vec%0d", i));

    // Parity: 0x07 -> XOR=1; even parity bit 1, odd parity bit 0
    run_frame(1, 16'h0007, {117'b0, 11'b0_11100000_1_1}, 11, 1, "B even");
    run_frame(2, 16'h0007, {117'b0, 11'b0_11100000_0_1}, 11, 1, "C odd");

    // Prescaled: words 0x81 then 0x3C, 2 stop bits, 1 gap bit, 4 clocks/bit
    run_frame(3, 16'h3C81, {105'b0, 23'b0_10000001_11_1_0_00111100_11}, 23, 4, "D presc");

    // en held high: back-to-back frames with one idle cycle between
    data_a = 16'hA55A;
    en_a = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 21; i++) begin
        chk($sformatf("held f%0d tx %0d", f, i), tx_a, (i < 20) ? seq_a55a[19-i] : 1'b1);
        chk($sformatf("held f%0d busy %0d", f, i), busy_a, (i < 20));
        chk($sformatf("held f%0d done %0d", f, i), done_a, (i == 20));
        if (done_a) done_cnt++;
        if (f == 1 && i == 20) en_a = 1'b0;
        @(negedge clk);
      end
    end
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL held done count: got %0d expected 2", done_cnt);
    end
    chk("held stop busy", busy_a, 1'b0);
    chk("held stop tx", tx_a, 1'b1);
    @(negedge clk);

    // Data change and en while busy are both ignored
    data_a = 16'h1234;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("latch tx %0d", i), tx_a, seq_1234[19-i]);
      if (i == 5) begin
        data_a = 16'hFFFF;
        en_a = 1'b1;
      end
      if (i == 7) en_a = 1'b0;
      @(negedge clk);
    end
    chk("latch done", done_a, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("latch no refire busy %0d", i), busy_a, 1'b0);
      chk($sformatf("latch no refire tx %0d", i), tx_a, 1'b1);
    end

    // Reset during word 1 DATA, while tx is low
    data_a = 16'hA55A;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    chk("pre-reset tx low", tx_a, 1'b0);
    chk("pre-reset busy", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("async reset tx", tx_a, 1'b1);
    chk("async reset busy", busy_a, 1'b0);
    chk("async reset done", done_a, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset idle tx", tx_a, 1'b1);
    chk("post-reset done", done_a, 1'b0);
    run_frame(0, 16'h8001, {108'b0, vecs[4].exp}, 20, 1, "A after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
